// File: rtl/spec_free_list_if.sv
// Rename-side handshake bundle for the speculative free list: allocation
// request/grant on one side, commit-time releases and recovery on the other.
interface spec_free_list_if #(
  parameter int SIZE_PHYSICAL_LOG = 7
);
  logic                         reqFreeReg_i;
  logic [SIZE_PHYSICAL_LOG-1:0] freeReg0_o;
  logic [SIZE_PHYSICAL_LOG-1:0] freeReg1_o;
  logic [SIZE_PHYSICAL_LOG-1:0] freeReg2_o;
  logic [SIZE_PHYSICAL_LOG-1:0] freeReg3_o;
  logic                         freeListEmpty_o;
  logic                         releasedValid0_i;
  logic                         releasedValid1_i;
  logic                         releasedValid2_i;
  logic                         releasedValid3_i;
  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap0_i;
  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap1_i;
  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap2_i;
  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap3_i;
  logic                         recoverFlag_i;

  modport master (
    output reqFreeReg_i,
    output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    output recoverFlag_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    input  freeListEmpty_o
  );

  modport slave (
    input  reqFreeReg_i,
    input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    input  recoverFlag_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    output freeListEmpty_o
  );
endinterface

// File: rtl/spec_free_list.sv
// Circular speculative free list: four-wide allocate at head, compacted release at tail.
// Define FREE_LIST_CHECK_EN to add the sticky overflow flag freeListErr_o and counter saturation.
module spec_free_list #(
  parameter int SIZE_PHYSICAL_TABLE = 96,
  parameter int SIZE_RMT            = 32,
  parameter int SIZE_PHYSICAL_LOG   = 7
) (
  input  logic clk,
  input  logic reset,
`ifdef FREE_LIST_CHECK_EN
  output logic freeListErr_o,
`endif
  spec_free_list_if.slave fl
);

  localparam int DEPTH = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spec_free_list: pool depth must be a power of two and at least 4");
  end

  logic [SIZE_PHYSICAL_LOG-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]             headPtr_q, headPtr_d;
  logic [PTR_W-1:0]             tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0]             freeCnt_q, freeCnt_d;

  logic [3:0]                   relValid;
  logic [SIZE_PHYSICAL_LOG-1:0] relTag [4];
  logic [2:0]                   slotOff [4];
  logic [2:0]                   relCnt;
  logic [PTR_W-1:0]             wrIdx [4];
  logic                         freeListEmpty;
  logic                         alloc;

  assign relValid  = {fl.releasedValid3_i, fl.releasedValid2_i,
                      fl.releasedValid1_i, fl.releasedValid0_i};
  assign relTag[0] = fl.releasedPhyMap0_i;
  assign relTag[1] = fl.releasedPhyMap1_i;
  assign relTag[2] = fl.releasedPhyMap2_i;
  assign relTag[3] = fl.releasedPhyMap3_i;

  // Each valid slot lands at tail plus the number of valid slots ahead of it.
  assign slotOff[0] = 3'd0;
  assign slotOff[1] = 3'(relValid[0]);
  assign slotOff[2] = 3'(relValid[0]) + 3'(relValid[1]);
  assign slotOff[3] = 3'(relValid[0]) + 3'(relValid[1]) + 3'(relValid[2]);
  assign relCnt     = slotOff[3] + 3'(relValid[3]);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wrIdx[k] = tailPtr_q + PTR_W'(slotOff[k]);
    end
  end

  assign freeListEmpty = (freeCnt_q < CNT_W'(4));
  assign alloc         = fl.reqFreeReg_i & ~freeListEmpty & ~fl.recoverFlag_i;

`ifdef FREE_LIST_CHECK_EN
  // One extra bit so an overflowing count is visible before saturation.
  logic [SUM_W-1:0] cntSum;
  logic             cntOvf;
  logic             err_q;

  assign cntSum = SUM_W'(freeCnt_q) + SUM_W'(relCnt) - (alloc ? SUM_W'(4) : SUM_W'(0));
  assign cntOvf = (cntSum > SUM_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cntOvf) begin
      err_q <= 1'b1;
    end
  end

  assign freeListErr_o = err_q;
`else
  logic [CNT_W-1:0] cntSum;

  assign cntSum = freeCnt_q + CNT_W'(relCnt) - (alloc ? CNT_W'(4) : CNT_W'(0));
`endif

  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q + PTR_W'(relCnt);
`ifdef FREE_LIST_CHECK_EN
    freeCnt_d = cntOvf ? CNT_W'(DEPTH) : cntSum[CNT_W-1:0];
`else
    freeCnt_d = cntSum;
`endif
    if (alloc) begin
      headPtr_d = headPtr_q + PTR_W'(4);
    end
    // Speculative tags still sit between tail and head, so snapping head reclaims them.
    if (fl.recoverFlag_i) begin
      headPtr_d = tailPtr_d;
      freeCnt_d = CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      freeCnt_q <= CNT_W'(DEPTH);
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      freeCnt_q <= freeCnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= SIZE_PHYSICAL_LOG'(SIZE_RMT + i);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (relValid[k]) begin
          entry_q[wrIdx[k]] <= relTag[k];
        end
      end
    end
  end

  assign fl.freeReg0_o      = entry_q[headPtr_q];
  assign fl.freeReg1_o      = entry_q[headPtr_q + PTR_W'(1)];
  assign fl.freeReg2_o      = entry_q[headPtr_q + PTR_W'(2)];
  assign fl.freeReg3_o      = entry_q[headPtr_q + PTR_W'(3)];
  assign fl.freeListEmpty_o = freeListEmpty;

endmodule

// File: doc/spec_free_list.md
# spec_free_list

Speculative free list for the rename stage, directly downstream of the architectural map table. The architectural map table releases up to four old physical mappings per cycle on commit, and this block returns them to a circular pool. Rename draws four free physical registers per cycle from that pool. On recovery, every speculatively allocated register is reclaimed in a single cycle by snapping the head pointer back to the tail.

## Interface
- `SIZE_PHYSICAL_TABLE`, 96: total physical registers.
- `SIZE_RMT`, 32: logical registers; these are the architecturally mapped ones at reset.
- `SIZE_PHYSICAL_LOG`, 7: physical tag width.
- `DEPTH` (derived), `SIZE_PHYSICAL_TABLE - SIZE_RMT` = 64: pool capacity. Must be a power of two and at least 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqFreeReg_i`  in  1  rename requests a bundle of four registers this cycle.
- `freeReg0_o` … `freeReg3_o`  out  `SIZE_PHYSICAL_LOG` each  the four tags at head … head+3.
- `freeListEmpty_o`  out  1  fewer than four entries are available; rename must stall.
- `releasedValid0_i` … `releasedValid3_i`  in  1 each  release slot valid, from the architectural map table.
- `releasedPhyMap0_i` … `releasedPhyMap3_i`  in  `SIZE_PHYSICAL_LOG` each  tag being returned.
- `recoverFlag_i`  in  1  exception or mispredict recovery pulse from the active list.
- `freeListErr_o`  out  1  sticky overflow/underflow flag. Present only with `FREE_LIST_CHECK_EN`.

## Operation
- **Storage:** `DEPTH` entries of `SIZE_PHYSICAL_LOG` bits.
- **Pointers:** `headPtr` and `tailPtr`, each log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
- **Counter:** `freeCnt`, log2(`DEPTH`)+1 bits.
- **Reset:**
  - entry i = `SIZE_RMT` + i;
  - `headPtr` = `tailPtr` = 0;
  - `freeCnt` = `DEPTH`;
  - `freeListErr_o` = 0.
- **Reset output values:**
  - `freeReg0_o` … `freeReg3_o` = 32, 33, 34, 35;
  - `freeListEmpty_o` = 0.
- **Read:**
  - `freeRegK_o` = entry[(`headPtr` + K) mod `DEPTH`], combinational from registered state.
  - `freeListEmpty_o` = (`freeCnt` < 4).
- **Allocate:** `alloc` = `reqFreeReg_i` & ~`freeListEmpty_o` & ~`recoverFlag_i`.
  - If `alloc`: `headPtr` += 4 and `freeCnt` −= 4.
  - Allocation is all-or-nothing; partial bundles are never issued.
  - A request made while empty is ignored and has no state effect.
- **Release:** n = popcount of `releasedValid0_i` … `releasedValid3_i` (0–4).
  - Valid tags are written compacted, in slot order (0 first), to `tailPtr`, `tailPtr`+1, ….
  - Invalid slots consume no entry.
  - `tailPtr` += n.
- **Simultaneous allocate and release:** `freeCnt`_next = `freeCnt` − 4·`alloc` + n. Both pointers move in the same cycle.
- **Recovery** (`recoverFlag_i` = 1):
  - Releases in that cycle are still written and `tailPtr` still advances by n.
  - `headPtr` ← `tailPtr` + n.
  - `freeCnt` ← `DEPTH`.
  - No allocation occurs that cycle.
  - Rationale: speculatively allocated tags still sit un-overwritten between tail and head, so snapping head back reclaims them all.
- **Reset mid-operation:** asynchronous return to the reset state above, regardless of pending request, release or recovery.

## Timing
- Allocation:
  - Tags are valid in the same cycle `reqFreeReg_i` is sampled (zero latency).
  - The head advance is visible on the outputs the following cycle.
- Release:
  - A released tag is allocatable no earlier than the cycle after the release edge.
  - There is no same-cycle bypass into `freeRegK_o`.
- `freeListEmpty_o` is a function of registered `freeCnt` only.
  - It deasserts the cycle after enough releases arrive.
  - It asserts the cycle after the allocation that drops `freeCnt` below 4.
- Recovery takes one cycle. Rename may request on the cycle after the `recoverFlag_i` pulse.
- Wrap-around: reads at head+K and writes at tail+K both wrap modulo `DEPTH` with no bubble.

## Configuration
- **`FREE_LIST_CHECK_EN` defined:**
  - Output `freeListErr_o` exists.
  - It sets, and stays set until reset, on any cycle where `freeCnt` − 4·`alloc` + n > `DEPTH` (overflow, double free).
  - Outside recovery, the counter saturates at `DEPTH`, but tail still advances.
- **`FREE_LIST_CHECK_EN` undefined:**
  - Port and checking logic are absent.
  - The counter arithmetic is unguarded, and overflow is undefined behaviour.

## Test plan
- **Reset:** assert reset mid-cycle, then release it.
  - `freeReg0_o` … `freeReg3_o` = 32, 33, 34, 35.
  - `freeListEmpty_o` = 0.
  - `freeCnt` = 64.
- **Single allocation:** one `reqFreeReg_i` pulse.
  - Outputs return 32 … 35 that cycle, then 36 … 39 the next.
  - `freeCnt` = 60.
- **Compacted release plus allocation:** in one cycle, `releasedValid0_i` = 1 (tag 5), `releasedValid2_i` = 1 (tag 9), and `reqFreeReg_i` = 1.
  - Entries 0 and 1 become 5 and 9.
  - `tailPtr` = 2.
  - `freeCnt` = 64 − 4 − 4 + 2 = 58.
- **Drain and wrap:** 16 consecutive requests from reset.
  - `freeListEmpty_o` = 1 and a 17th request is ignored.
  - Release 4 tags (10, 11, 12, 13); the next cycle empty = 0 and the outputs are 10, 11, 12, 13 (wrapped to index 0).
- **Recovery:** 3 allocations (`freeCnt` 52), then a `recoverFlag_i` pulse together with `reqFreeReg_i`.
  - No allocation occurs that cycle.
  - The next cycle `freeCnt` = 64 and the outputs are 32 … 35.
- **Overflow check** (with `FREE_LIST_CHECK_EN`): from reset, release 1 tag with no allocation.
  - `freeListErr_o` = 1 the next cycle and stays 1 until reset.
